ir_packet_tx: RTL
=================

# ir_packet_tx

Per-car IR packet transmitter: turns a 4-bit drive command and a one-cycle send strobe into a carrier-modulated IR packet on a single LED output. It sits directly downstream of the IR bus peripheral. That peripheral supplies `COMMAND` (from its bus-written register) and the 10 Hz `SEND_PACKET` strobe, then selects one transmitter's `IR_LED` per car type. Each instance is parameterised for one car colour's carrier frequency and field lengths.

## Interface
- `HCYC_PULSE`, 1388, carrier half-period in clocks minus 1 (1388 gives 36 kHz at 100 MHz)
- `SZ_START`, 190, start burst length in carrier periods minus 1
- `SZ_CARSEL`, 46, car-select burst length in periods minus 1
- `SZ_GAP`, 24, inter-field gap length in periods minus 1
- `SZ_ASSERT`, 46, burst length for a command bit = 1, in periods minus 1
- `SZ_DEASSERT`, 21, burst length for a command bit = 0, in periods minus 1
- `CLK`  in  1  system clock (100 MHz)
- `RESET`  in  1  synchronous, active-high reset
- `COMMAND`  in  4  drive command: [0] Right, [1] Left, [2] Backward, [3] Forward
- `SEND_PACKET`  in  1  one-cycle strobe requesting one packet
- `IR_LED`  out  1  modulated IR output (registered)
- `BUSY`  out  1  high while a packet is pending or in transmission (registered)

## Operation
- Carrier generator, free-running from reset:
  - half-cycle counter `hc` counts 0..`HCYC_PULSE` and wraps;
  - `carrier` toggles on each wrap; period = 2*(`HCYC_PULSE`+1) clocks.
- Period tick: the cycle where `hc`==`HCYC_PULSE` and `carrier`==0, i.e. the cycle before `carrier` rises. All state and field-counter updates happen only on ticks.
- Acceptance:
  - `SEND_PACKET`=1 while `BUSY`=0 accepts a request;
  - `COMMAND` is latched into an internal register that same edge;
  - `BUSY`=1 from the next cycle;
  - `SEND_PACKET` while `BUSY`=1 is ignored, and the latched command is unchanged.
- States and packet order:
  - `IDLE`, `START`, `GAP0`, `CARSEL`, `GAP1`, `RIGHT`, `GAP2`, `LEFT`, `GAP3`, `BACK`, `GAP4`, `FWD`, `GAP5`, then `IDLE`.
  - Every field is a burst or gap of (SZ+1) periods.
  - Bit fields use `SZ_ASSERT` if the latched bit is 1, otherwise `SZ_DEASSERT`.
- Leaving `IDLE`: with a request pending, the first tick at least one cycle after the acceptance cycle enters `START` and clears the field counter.
- Field counter:
  - increments on each tick in the current state;
  - on a tick with counter == the field's SZ, the state advances and the counter clears.
- Output:
  - `IR_LED` = `carrier` AND (state is a burst state: `START`, `CARSEL`, `RIGHT`, `LEFT`, `BACK`, `FWD`);
  - it is registered and aligned so each burst begins on the first carrier-high cycle after the entering tick;
  - `IR_LED` = 0 in gaps and in `IDLE`.
- `BUSY` clears on the edge that moves `GAP5` to `IDLE`. A strobe in that same cycle is ignored (`BUSY` is still 1).
- Counter widths: sized to hold the largest SZ parameter and `HCYC_PULSE`; no wrap occurs within a field.

## Timing
- Reset values: `IR_LED`=0, `BUSY`=0, state `IDLE`, `hc`=0, `carrier`=0, field counter 0, latched command 0.
- `RESET` mid-packet aborts immediately: all of the above take reset values on that edge. The upstream block drives `RESET` high when the car type changes.
- Start latency: from acceptance to first `IR_LED` high is between 2 and 2*(`HCYC_PULSE`+1)+1 clocks, depending on carrier phase.
- Each field lasts exactly (SZ+1)*2*(`HCYC_PULSE`+1) clocks, with no dropped or extra periods at field boundaries.
- Each burst period contributes exactly `HCYC_PULSE`+1 high cycles of `IR_LED`.
- Packet length in periods = (`SZ_START`+1) + (`SZ_CARSEL`+1) + 6*(`SZ_GAP`+1) + Σ over bits of bit burst length. The packet must fit within the strobe interval; overrun strobes are dropped, never queued.

## Test plan
Bench parameters for every scenario: `HCYC_PULSE`=1 (4-clock period), `SZ_START`=3, `SZ_CARSEL`=1, `SZ_GAP`=0, `SZ_ASSERT`=2, `SZ_DEASSERT`=0.
- **Reset:** hold `RESET` 5 cycles, then idle 40 cycles with no strobe -> `IR_LED`=0 and `BUSY`=0 throughout, carrier toggles every 2 clocks.
- **All-zero command:** strobe with `COMMAND`=0000 -> packet of 16 periods (64 clocks from `START` entry to `IDLE`), 20 `IR_LED`-high cycles, burst pattern 4/2/1/1/1/1 periods.
- **All-ones command:** strobe with `COMMAND`=1111 -> 24 periods (96 clocks), 36 high cycles, bit bursts 3 periods each.
- **Mixed command:** strobe with `COMMAND`=1010 -> 20 periods (80 clocks), 28 high cycles. Bursts are Right=1, Left=3, Back=1, Fwd=3 periods.
- **Strobe while busy:** second strobe with `COMMAND`=1111 mid-packet of 0000 -> ignored; packet stays 0000; `BUSY` drops once; no second packet.
- **Reset mid-burst:** `RESET` pulse during `CARSEL` -> `IR_LED`=0 and `BUSY`=0 on the next edge. A strobe after reset sends a full, correct packet.

Source files
------------

// File: rtl/ir_packet_tx.sv
// Per-car IR packet transmitter: serialises a latched 4-bit drive command into
// carrier-modulated start / car-select / command-bit bursts separated by gaps.
module ir_packet_tx #(
   parameter int unsigned HCYC_PULSE  = 1388,
   parameter int unsigned SZ_START    = 190,
   parameter int unsigned SZ_CARSEL   = 46,
   parameter int unsigned SZ_GAP      = 24,
   parameter int unsigned SZ_ASSERT   = 46,
   parameter int unsigned SZ_DEASSERT = 21
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] COMMAND,
   input  logic       SEND_PACKET,
   output logic       IR_LED,
   output logic       BUSY
);

   localparam int unsigned MAX_A   = (SZ_START > SZ_CARSEL) ? SZ_START : SZ_CARSEL;
   localparam int unsigned MAX_B   = (SZ_GAP > SZ_ASSERT) ? SZ_GAP : SZ_ASSERT;
   localparam int unsigned MAX_C   = (SZ_DEASSERT > HCYC_PULSE) ? SZ_DEASSERT : HCYC_PULSE;
   localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_GAP0, S_CARSEL, S_GAP1, S_RIGHT, S_GAP2,
      S_LEFT, S_GAP3, S_BACK, S_GAP4, S_FWD, S_GAP5
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   hc_q;
   logic            carrier_q;
   logic [3:0]      cmd_q;
   logic            busy_q, busy_d;
   logic            led_q, led_d;
   logic            hc_wrap_c, tick_c, accept_c, carrier_d_c;
   logic [CW-1:0]   field_sz_c;

   function automatic state_t next_field(input state_t s);
      case (s)
         S_START:  return S_GAP0;
         S_GAP0:   return S_CARSEL;
         S_CARSEL: return S_GAP1;
         S_GAP1:   return S_RIGHT;
         S_RIGHT:  return S_GAP2;
         S_GAP2:   return S_LEFT;
         S_LEFT:   return S_GAP3;
         S_GAP3:   return S_BACK;
         S_BACK:   return S_GAP4;
         S_GAP4:   return S_FWD;
         S_FWD:    return S_GAP5;
         default:  return S_IDLE;
      endcase
   endfunction

   function automatic logic [CW-1:0] bit_len(input logic b);
      return b ? CW'(SZ_ASSERT) : CW'(SZ_DEASSERT);
   endfunction

   function automatic logic [CW-1:0] field_len(input state_t s, input logic [3:0] c);
      case (s)
         S_START:  return CW'(SZ_START);
         S_CARSEL: return CW'(SZ_CARSEL);
         S_RIGHT:  return bit_len(c[0]);
         S_LEFT:   return bit_len(c[1]);
         S_BACK:   return bit_len(c[2]);
         S_FWD:    return bit_len(c[3]);
         default:  return CW'(SZ_GAP);
      endcase
   endfunction

   function automatic logic is_burst(input state_t s);
      case (s)
         S_START, S_CARSEL, S_RIGHT, S_LEFT, S_BACK, S_FWD: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign hc_wrap_c  = (hc_q == CW'(HCYC_PULSE));
   assign tick_c     = hc_wrap_c && !carrier_q;
   assign accept_c   = SEND_PACKET && !busy_q;
   assign field_sz_c = field_len(state_q, cmd_q);

   // Free-running carrier and command latch
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hc_q      <= '0;
         carrier_q <= 1'b0;
         cmd_q     <= 4'b0000;
      end else begin
         hc_q <= hc_wrap_c ? '0 : hc_q + CW'(1);
         if (hc_wrap_c) carrier_q <= ~carrier_q;
         if (accept_c)  cmd_q     <= COMMAND;
      end
   end

   // State register with registered outputs
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
      end
   end

   // Next state: fields advance only on carrier period ticks
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (accept_c) busy_d = 1'b1;
      if (tick_c) begin
         if (state_q == S_IDLE) begin
            if (busy_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end else if (cnt_q == field_sz_c) begin
            state_d = next_field(state_q);
            cnt_d   = '0;
            if (state_q == S_GAP5) busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // LED register tracks next-cycle carrier so bursts start on carrier rise
   always_comb begin
      carrier_d_c = carrier_q ^ hc_wrap_c;
      led_d       = carrier_d_c && is_burst(state_d);
   end

   assign IR_LED = led_q;
   assign BUSY   = busy_q;

endmodule
